int_req_latch: RTL and testbench
================================

Name: int_req_latch

Overview:
- Upstream stage of the interrupt-priority selector.
- Synchronises the raw external interrupt sources and latches each rising edge into the request register IR.
- Keeps the in-service register IRS up to date as the pipeline accepts interrupts (ack) and returns from them (eret).
- The selector consumes IR and IRS combinationally and returns its one-hot choice as ack_id when the pipeline takes the interrupt.

Parameters:
- N_INT, 3, number of interrupt sources; bit N_INT-1 has the highest priority.
- SYNC_STAGES, 2, flip-flop stages in each source synchroniser (minimum 2).

Ports:
- clk  input  1  system clock, rising edge active
- rst  input  1  asynchronous, active-high reset
- int_src  input  N_INT  raw external interrupt lines, asynchronous to clk, level; a rising edge is one request
- int_ack  input  1  one-cycle pulse: pipeline enters the handler selected by ack_id this cycle
- ack_id  input  N_INT  one-hot id of the accepted interrupt; sampled only when int_ack=1
- eret  input  1  one-cycle pulse: pipeline returns from the current (highest in-service) handler
- IR  output  N_INT  latched pending requests, registered
- IRS  output  N_INT  in-service bits (nesting set), registered
- depth  output  2  number of set IRS bits (0..N_INT), registered
- ack_err  output  1  sticky flag for an illegal ack; cleared only by rst

Behaviour:
- Reset (async, rst=1): IR=0, IRS=0, depth=0, ack_err=0, all synchroniser and edge-history flops=0. Outputs hold these values while rst is high.
- Sync/edge, per source i:
  - int_src[i] passes through a SYNC_STAGES flop chain; the last stage is s[i].
  - prev[i] is s[i] delayed by one cycle.
  - rise[i] = s[i] & ~prev[i].
  - Latency from a source edge to IR[i]=1 is SYNC_STAGES+1 clk edges (3 at default).
  - A source held high produces exactly one request. It must go low for at least one synchronised cycle before it can request again.
- Legal ack: int_ack=1, ack_id one-hot, and IR[ack_id]=1 and IRS[ack_id]=0 (values before the edge).
- IR update at each edge, bit i:
  - Set if rise[i].
  - Else clear if legal ack with ack_id[i]=1.
  - Else hold.
  - A new edge in the same cycle as the ack of that source wins: IR[i] stays 1.
- IRS update at each edge, computed from the pre-edge IRS:
  - If eret=1 and IRS!=0, clear the highest-index set bit. If eret=1 and IRS=0, no change.
  - Then, if legal ack, set bit ack_id.
  - With eret and ack in the same cycle, both apply in that order (e.g. IRS=100, ack_id=010 -> IRS=010).
- Illegal ack: int_ack=1 with ack_id zero, multi-hot, IR bit 0, or IRS bit already 1.
  - IR and IRS are unchanged by the ack.
  - ack_err is set to 1 at that edge.
  - An eret in the same cycle is still applied.
- depth: registered popcount of the next IRS value, so it always matches IRS in the same cycle.
- int_ack and eret are level-sampled each cycle. A pulse held for two cycles counts as two events; the second ack is illegal because IRS is already set.
- No other state. Mid-operation reset clears everything immediately; requests pending at reset are lost.

Decomposition:
- Shared package int_pkg:
  - N_INT_DEF=3.
  - Priority index constants INT_HI=2, INT_MID=1, INT_LO=0.
  - A function returning the highest set bit of an N_INT vector; also used by the selector and this block for eret.
- One natural sub-module, int_edge_sync:
  - Parameter SYNC_STAGES; ports clk, rst, din, rise.
  - Instantiated N_INT times.
  - The top level holds IR, IRS, depth and ack_err logic.

Test Plan:
- Reset: assert rst mid-run with IR=101, IRS=010 -> IR, IRS, depth and ack_err all read 0 asynchronously, before the next clk edge.
- Edge latch: raise int_src=001 at cycle 0 and hold high for 10 cycles -> IR=001 from cycle 3 onward, never re-set after an ack, and no second request.
- Nested accept: IR=011. Ack 010 -> IR=001, IRS=010, depth=1. Raise source 2 -> IR=101. Ack 100 -> IR=001, IRS=110, depth=2.
- Eret order: IRS=110. Eret -> IRS=010. Eret -> IRS=000. Third eret -> no change, ack_err=0.
- Simultaneous events:
  - IRS=100, IR=010; eret plus ack 010 in one cycle -> IRS=010, IR=000.
  - rise[1] coincident with ack 010 -> IR[1] stays 1.
- Illegal ack: ack_id=011; then ack_id=001 with IR=000; then ack of a bit already in IRS -> IR and IRS unchanged each time, ack_err=1 after the first and sticky until rst.

Source files
------------

// File: rtl/int_pkg.sv
// rtl/int_pkg.sv - shared constants and helpers for the interrupt request/selector path
package int_pkg;

  localparam int N_INT_DEF = 3;
  localparam int INT_HI    = 2;
  localparam int INT_MID   = 1;
  localparam int INT_LO    = 0;

  // Helper vectors are this wide so any N_INT up to it can share the function
  localparam int INT_VEC_W = 16;

  // One-hot mask of the highest set bit of v (zero when v is zero)
  function automatic logic [INT_VEC_W-1:0] int_hi_bit(input logic [INT_VEC_W-1:0] v);
    logic [INT_VEC_W-1:0] m;
    m = '0;
    for (int i = 0; i < INT_VEC_W; i++) begin
      if (v[i]) m = INT_VEC_W'(1) << i;
    end
    return m;
  endfunction

endpackage

// File: rtl/int_edge_sync.sv
// rtl/int_edge_sync.sv - per-source synchroniser with rising-edge detect
module int_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  // Shift the raw line through the synchroniser and keep one cycle of history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign rise = chain[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/int_req_latch.sv
// rtl/int_req_latch.sv - latches interrupt edges into IR and tracks the in-service set IRS
module int_req_latch
  import int_pkg::*;
#(
  parameter int N_INT       = N_INT_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_INT-1:0] int_src,
  input  logic             int_ack,
  input  logic [N_INT-1:0] ack_id,
  input  logic             eret,
  output logic [N_INT-1:0] IR,
  output logic [N_INT-1:0] IRS,
  output logic [1:0]       depth,
  output logic             ack_err
);

  logic [N_INT-1:0] rise;
  logic             id_onehot;
  logic             ack_legal;
  logic [N_INT-1:0] ack_mask;
  logic [N_INT-1:0] irs_hi;
  logic [N_INT-1:0] ir_next;
  logic [N_INT-1:0] irs_next;
  logic [1:0]       depth_next;

  for (genvar g = 0; g < N_INT; g++) begin : g_sync
    int_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (int_src[g]),
      .rise (rise[g])
    );
  end

  assign irs_hi = N_INT'(int_hi_bit(INT_VEC_W'(IRS)));

  // An ack is honoured only for a single pending, not-yet-in-service source
  always_comb begin
    id_onehot = (ack_id != '0) && ((ack_id & (ack_id - N_INT'(1))) == '0);
    ack_legal = int_ack && id_onehot && ((ack_id & IR & ~IRS) != '0);
    ack_mask  = ack_legal ? ack_id : '0;
  end

  // Next-state: a new edge beats the ack clear; eret retires before the ack enters
  always_comb begin
    ir_next  = rise | (IR & ~ack_mask);
    irs_next = (eret ? (IRS & ~irs_hi) : IRS) | ack_mask;
    depth_next = '0;
    for (int i = 0; i < N_INT; i++) begin
      depth_next = depth_next + 2'(irs_next[i]);
    end
  end

  // Register request, in-service, nesting depth and the sticky illegal-ack flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      IR      <= '0;
      IRS     <= '0;
      depth   <= '0;
      ack_err <= 1'b0;
    end else begin
      IR      <= ir_next;
      IRS     <= irs_next;
      depth   <= depth_next;
      ack_err <= ack_err | (int_ack & ~ack_legal);
    end
  end

endmodule

// File: tb/tb_int_req_latch.sv
// tb/tb_int_req_latch.sv - directed self-checking bench for int_req_latch
module tb_int_req_latch;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] int_src;
  logic       int_ack;
  logic [2:0] ack_id;
  logic       eret;
  logic [2:0] IR;
  logic [2:0] IRS;
  logic [1:0] depth;
  logic       ack_err;

  int total = 0;
  int bad   = 0;

  int_req_latch #(.N_INT(3), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .int_src (int_src),
    .int_ack (int_ack),
    .ack_id  (ack_id),
    .eret    (eret),
    .IR      (IR),
    .IRS     (IRS),
    .depth   (depth),
    .ack_err (ack_err)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [2:0] e_ir, input logic [2:0] e_irs,
                           input logic [1:0] e_depth, input logic e_err);
    chk({tag, ".IR"},    8'(IR),      8'(e_ir));
    chk({tag, ".IRS"},   8'(IRS),     8'(e_irs));
    chk({tag, ".depth"}, 8'(depth),   8'(e_depth));
    chk({tag, ".err"},   8'(ack_err), 8'(e_err));
  endtask

  task automatic ack(input logic [2:0] id, input logic with_eret);
    int_ack = 1'b1;
    ack_id  = id;
    eret    = with_eret;
    tick();
    int_ack = 1'b0;
    ack_id  = 3'b000;
    eret    = 1'b0;
  endtask

  task automatic do_eret();
    eret = 1'b1;
    tick();
    eret = 1'b0;
  endtask

  initial begin
    rst = 1'b1; int_src = 3'b000; int_ack = 1'b0; ack_id = 3'b000; eret = 1'b0;
    tick(2);
    chk_state("reset", 3'b000, 3'b000, 2'd0, 1'b0);
    rst = 1'b0;
    tick();

    // Edge latch: latency of three edges, one request for a held level
    int_src = 3'b001;
    tick(2);
    chk("lat.edge2", 8'(IR), 8'h0);
    tick();
    chk("lat.edge3", 8'(IR), 8'h1);
    tick(2);
    chk("lat.hold", 8'(IR), 8'h1);
    ack(3'b001, 1'b0);
    chk_state("lat.ack", 3'b000, 3'b001, 2'd1, 1'b0);
    tick(5);
    chk("lat.noreq", 8'(IR), 8'h0);
    do_eret();
    chk_state("lat.eret", 3'b000, 3'b000, 2'd0, 1'b0);
    int_src = 3'b000;
    tick(4);

    // Nested accept
    int_src = 3'b011;
    tick(3);
    chk("nest.ir", 8'(IR), 8'h3);
    ack(3'b010, 1'b0);
    chk_state("nest.ack1", 3'b001, 3'b010, 2'd1, 1'b0);
    int_src = 3'b111;
    tick(3);
    chk("nest.src2", 8'(IR), 8'h5);
    ack(3'b100, 1'b0);
    chk_state("nest.ack2", 3'b001, 3'b110, 2'd2, 1'b0);

    // Eret order: highest in-service first, eret on empty set is harmless
    do_eret();
    chk_state("eret1", 3'b001, 3'b010, 2'd1, 1'b0);
    do_eret();
    chk_state("eret2", 3'b001, 3'b000, 2'd0, 1'b0);
    do_eret();
    chk_state("eret3", 3'b001, 3'b000, 2'd0, 1'b0);

    // Build IRS=100, IR=010 then eret and ack together
    int_src = 3'b000;
    tick(4);
    ack(3'b001, 1'b0);
    do_eret();
    chk_state("sim.prep", 3'b000, 3'b000, 2'd0, 1'b0);
    int_src = 3'b100;
    tick(3);
    ack(3'b100, 1'b0);
    int_src = 3'b110;
    tick(3);
    chk_state("sim.pre", 3'b010, 3'b100, 2'd1, 1'b0);
    ack(3'b010, 1'b1);
    chk_state("sim.eret_ack", 3'b000, 3'b010, 2'd1, 1'b0);

    // Rise of source 1 on the same edge as its ack keeps IR[1]
    do_eret();
    int_src = 3'b100;
    tick(4);
    int_src = 3'b110;
    tick(3);
    chk("rise.ir", 8'(IR), 8'h2);
    int_src = 3'b100;
    tick(4);
    int_src = 3'b110;
    tick(2);
    ack(3'b010, 1'b0);
    chk_state("rise.ack", 3'b010, 3'b010, 2'd1, 1'b0);

    // Illegal acks leave IR/IRS alone and set the sticky flag
    ack(3'b011, 1'b0);
    chk_state("ill.multi", 3'b010, 3'b010, 2'd1, 1'b1);
    ack(3'b010, 1'b0);
    chk_state("ill.inserv", 3'b010, 3'b010, 2'd1, 1'b1);
    ack(3'b001, 1'b0);
    chk_state("ill.nopend", 3'b010, 3'b010, 2'd1, 1'b1);
    ack(3'b001, 1'b1);
    chk_state("ill.eret", 3'b010, 3'b000, 2'd0, 1'b1);
    tick(3);
    chk("ill.sticky", 8'(ack_err), 8'h1);

    // Mid-run asynchronous reset with IR=101, IRS=010
    ack(3'b010, 1'b0);
    int_src = 3'b010;
    tick(4);
    int_src = 3'b111;
    tick(3);
    chk_state("rst.pre", 3'b101, 3'b010, 2'd1, 1'b1);
    #2 rst = 1'b1;
    #1 chk_state("rst.async", 3'b000, 3'b000, 2'd0, 1'b0);
    int_src = 3'b000;
    tick(2);
    rst = 1'b0;
    tick(5);
    chk_state("rst.after", 3'b000, 3'b000, 2'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
